// File: rtl/us_replicate.sv
// 2x nearest-neighbour upscaler: sync/DE pixel stream in, valid/ready out.
// Two ping-pong line buffers; each line is read out twice, each pixel twice.
module us_replicate #(
  parameter int WIDTH = 10,
  parameter int HACT  = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_r_data,
  input  logic [WIDTH-1:0] i_g_data,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sof,
  output logic             o_eol,
  output logic [WIDTH-1:0] o_r_data,
  output logic [WIDTH-1:0] o_g_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic             o_overflow
);

  localparam int AW = $clog2(HACT);
  localparam int PW = $clog2(HACT + 1);
  localparam int BW = AW + 1;
  localparam int DW = 3 * WIDTH;
  localparam logic [PW-1:0] HMAX = PW'(HACT);
  localparam logic [PW:0]   ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_LINE0, S_LINE1
  } state_t;

  state_t        state_q;
  logic          vs_q, de_q;
  logic          wr_sel_q, rd_sel_q;
  logic [1:0]    full_q, sof_tag_q;
  logic [PW-1:0] len_q [2];
  logic [PW-1:0] wr_ptr_q;
  logic          drop_q, sof_arm_q, ovf_q;
  logic [BW-1:0] beat_q;
  logic [DW-1:0] lb_q [2][HACT];

  logic          unused_hs;
  logic          v_r, d_f, first;
  logic [PW-1:0] cur_len;
  logic [PW:0]   len2, beat_x;
  logic          last, xfer, rel;
  logic          wr_busy, accept, wr_en, commit;
  logic [DW-1:0] pix;

  assign unused_hs = i_hsync;

  assign v_r   = i_vsync & ~vs_q;
  assign d_f   = ~i_de & de_q;
  assign first = i_de & ~de_q;

  assign cur_len = len_q[rd_sel_q];
  assign len2    = {cur_len, 1'b0};
  assign beat_x  = (PW+1)'(beat_q);
  assign last    = (beat_x == len2 - ONE);
  assign xfer    = (state_q != S_IDLE) & i_ready;
  assign rel     = (state_q == S_LINE1) & xfer & last;

  // A buffer released on this very edge is already free for a new line.
  assign wr_busy = full_q[wr_sel_q] &
                   ~(rel & (rd_sel_q == wr_sel_q));
  assign accept  = first ? ~wr_busy : ~drop_q;
  assign wr_en   = i_de & accept & ~v_r &
                   (wr_ptr_q < HMAX);
  assign commit  = d_f & ~drop_q & ~v_r &
                   (wr_ptr_q != '0);

  always_ff @(posedge clk) begin
    if (wr_en)
      lb_q[wr_sel_q][wr_ptr_q[AW-1:0]] <=
        {i_r_data, i_g_data, i_b_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      full_q    <= '0;
      sof_tag_q <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wr_ptr_q  <= '0;
      drop_q    <= 1'b0;
      sof_arm_q <= 1'b0;
      ovf_q     <= 1'b0;
      beat_q    <= '0;
    end else begin
      vs_q <= i_vsync;
      de_q <= i_de;

      if (first & wr_busy)
        drop_q <= 1'b1;
      else if (d_f)
        drop_q <= 1'b0;

      if (v_r)
        ovf_q <= 1'b0;
      else if (first & wr_busy)
        ovf_q <= 1'b1;

      if (v_r | d_f)
        wr_ptr_q <= '0;
      else if (wr_en)
        wr_ptr_q <= wr_ptr_q + PW'(1);

      if (v_r)
        sof_arm_q <= 1'b1;
      else if (commit)
        sof_arm_q <= 1'b0;

      if (commit) begin
        full_q[wr_sel_q]    <= 1'b1;
        len_q[wr_sel_q]     <= wr_ptr_q;
        sof_tag_q[wr_sel_q] <= sof_arm_q;
        wr_sel_q            <= ~wr_sel_q;
      end

      unique case (state_q)
        S_IDLE: begin
          beat_q <= '0;
          if (full_q[rd_sel_q])
            state_q <= S_LINE0;
        end
        S_LINE0: begin
          if (xfer) begin
            if (last) begin
              state_q <= S_LINE1;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        S_LINE1: begin
          if (xfer) begin
            if (last) begin
              state_q          <= S_IDLE;
              beat_q           <= '0;
              full_q[rd_sel_q] <= 1'b0;
              rd_sel_q         <= ~rd_sel_q;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix     = lb_q[rd_sel_q][beat_q[BW-1:1]];
  assign o_valid = (state_q != S_IDLE);
  assign o_sof   = (state_q == S_LINE0) &
                   (beat_q == '0) & sof_tag_q[rd_sel_q];
  assign o_eol   = o_valid & last;

  assign o_r_data = o_valid ? pix[DW-1:2*WIDTH]     : '0;
  assign o_g_data = o_valid ? pix[2*WIDTH-1:WIDTH]  : '0;
  assign o_b_data = o_valid ? pix[WIDTH-1:0]        : '0;

  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_us_replicate.sv
// Scoreboard bench for us_replicate (HACT=4): expected beats are queued
// by the stimulus side and consumed by an independent monitor.
module tb_us_replicate;

  localparam int W = 10;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_vsync = 1'b0;
  logic         i_hsync = 1'b0;
  logic         i_de = 1'b0;
  logic [W-1:0] i_r_data = '0;
  logic [W-1:0] i_g_data = '0;
  logic [W-1:0] i_b_data = '0;
  logic         i_ready = 1'b1;
  logic         o_valid, o_sof, o_eol, o_overflow;
  logic [W-1:0] o_r_data, o_g_data, o_b_data;

  us_replicate #(.WIDTH(W), .HACT(H)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_vsync   (i_vsync),
    .i_hsync   (i_hsync),
    .i_de      (i_de),
    .i_r_data  (i_r_data),
    .i_g_data  (i_g_data),
    .i_b_data  (i_b_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sof     (o_sof),
    .o_eol     (o_eol),
    .o_r_data  (o_r_data),
    .o_g_data  (o_g_data),
    .o_b_data  (o_b_data),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         sof;
    logic         eol;
  } beat_t;

  beat_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int start,
                           input int n,
                           input bit sof);
    beat_t e;
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < 2 * n; k++) begin
        e.r   = W'(start + k / 2);
        e.g   = W'(start + k / 2 + 100);
        e.b   = W'(start + k / 2 + 200);
        e.sof = sof && rep == 0 && k == 0;
        e.eol = (k == 2 * n - 1);
        q.push_back(e);
      end
  endtask

  task automatic send_line(input int start,
                           input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      i_de     = 1'b1;
      i_r_data = W'(start + i);
      i_g_data = W'(start + i + 100);
      i_b_data = W'(start + i + 200);
    end
    tick();
    i_de     = 1'b0;
    i_r_data = '0;
    i_g_data = '0;
    i_b_data = '0;
  endtask

  task automatic vsync();
    tick();
    i_vsync = 1'b1;
    i_hsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    i_hsync = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && q.size() != 0; i++)
      @(negedge clk);
    chk("drain", q.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: checks every presented beat against the queue head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("no_beat_expected", {31'd0, o_valid}, 0);
      end else if (o_valid) begin
        e = q[0];
        chk("beat_r", {22'd0, o_r_data}, {22'd0, e.r});
        chk("beat_g", {22'd0, o_g_data}, {22'd0, e.g});
        chk("beat_b", {22'd0, o_b_data}, {22'd0, e.b});
        chk("beat_sof", {31'd0, o_sof}, {31'd0, e.sof});
        chk("beat_eol", {31'd0, o_eol}, {31'd0, e.eol});
        if (i_ready)
          void'(q.pop_front());
      end
      if (!o_valid)
        chk("idle_zero",
            {o_r_data, o_g_data, o_b_data, o_sof, o_eol},
            0);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_sof", {31'd0, o_sof}, 0);
    chk("rst_eol", {31'd0, o_eol}, 0);
    chk("rst_ovf", {31'd0, o_overflow}, 0);
    chk("rst_r", {22'd0, o_r_data}, 0);
    tick();
    rstn = 1'b1;
    repeat (2) tick();

    // 1: basic line, latency
    i_ready = 1'b1;
    vsync();
    push_line(1, 4, 1'b1);
    send_line(1, 4);
    @(negedge clk);
    chk("lat_e0", {31'd0, o_valid}, 0);
    tick();
    @(negedge clk);
    chk("lat_e1", {31'd0, o_valid}, 0);
    tick();
    @(negedge clk);
    chk("lat_e2", {31'd0, o_valid}, 1);
    chk("lat_sof", {31'd0, o_sof}, 1);
    wait_drain();

    // 2: stall on beat 3, no sof without new vsync
    push_line(1, 4, 1'b0);
    send_line(1, 4);
    repeat (5) tick();
    chk("stall_beat3", {22'd0, o_r_data}, 2);
    i_ready = 1'b0;
    repeat (3) tick();
    chk("stall_hold", {22'd0, o_r_data}, 2);
    i_ready = 1'b1;
    wait_drain();

    // 3: overflow with downstream stalled
    i_ready = 1'b0;
    vsync();
    push_line(10, 4, 1'b1);
    push_line(20, 4, 1'b0);
    send_line(10, 4);
    repeat (2) tick();
    send_line(20, 4);
    repeat (2) tick();
    chk("ovf_before", {31'd0, o_overflow}, 0);
    send_line(30, 4);
    tick();
    @(negedge clk);
    chk("ovf_set", {31'd0, o_overflow}, 1);
    tick();
    i_vsync = 1'b1;
    tick();
    @(negedge clk);
    chk("ovf_clear", {31'd0, o_overflow}, 0);
    tick();
    i_vsync = 1'b0;
    i_ready = 1'b1;
    wait_drain();

    // 4: short line
    vsync();
    push_line(7, 3, 1'b1);
    send_line(7, 3);
    wait_drain();

    // 5: over-long line truncated to HACT
    vsync();
    push_line(1, 4, 1'b1);
    send_line(1, 6);
    wait_drain();
    chk("trunc_ovf", {31'd0, o_overflow}, 0);

    // 6: async reset during LINE1 beat 2
    vsync();
    push_line(1, 4, 1'b1);
    send_line(1, 4);
    repeat (12) tick();
    chk("pre_rst_valid", {31'd0, o_valid}, 1);
    chk("pre_rst_r", {22'd0, o_r_data}, 2);
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 0);
    chk("arst_eol", {31'd0, o_eol}, 0);
    chk("arst_sof", {31'd0, o_sof}, 0);
    chk("arst_r", {22'd0, o_r_data}, 0);
    chk("beats_left", q.size(), 6);
    q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) tick();
    chk("post_rst_ovf", {31'd0, o_overflow}, 0);
    vsync();
    push_line(40, 4, 1'b1);
    send_line(40, 4);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
